// File: rtl/band_level_meter.sv
// band_level_meter: per-band windowed max, decay and peak-hold with a registered read port
module band_level_meter #(
  parameter int NUM_BANDS    = 6,
  parameter int PWR_W        = 11,
  parameter int WIN_LOG2     = 8,
  parameter int DECAY_STEP   = 4,
  parameter int HOLD_WINDOWS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_en,
  input  logic [NUM_BANDS*PWR_W-1:0] power_bus,
  input  logic [2:0]                 rd_band,
  output logic [PWR_W-1:0]           rd_level,
  output logic [PWR_W-1:0]           rd_peak,
  output logic                       update
);
  localparam int IW = $clog2(NUM_BANDS);
  localparam int HW = $clog2(HOLD_WINDOWS + 1);
  localparam logic [PWR_W-1:0] DEC = PWR_W'(DECAY_STEP);
  typedef enum logic [1:0] {ACCUM, UPDATE, DONE} state_t;
  state_t state, state_nxt;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [PWR_W-1:0] win_max [NUM_BANDS];
  logic [PWR_W-1:0] wmx [NUM_BANDS];
  logic [PWR_W-1:0] snap [NUM_BANDS];
  logic [PWR_W-1:0] level [NUM_BANDS];
  logic [PWR_W-1:0] peak [NUM_BANDS];
  logic [HW-1:0] hold [NUM_BANDS];
  logic [IW-1:0] idx, idx_nxt;
  logic go, go_nxt, pending, pending_nxt, close;
  logic [PWR_W-1:0] s, lv_dec, pk_dec, lvl_new, pk_new;
  logic [HW-1:0] hold_new;
  assign close = sample_en && (&win_cnt);
  always_comb
    for (int k = 0; k < NUM_BANDS; k++)
      wmx[k] = power_bus[k*PWR_W +: PWR_W] > win_max[k] ? power_bus[k*PWR_W +: PWR_W] : win_max[k];
  // Shared per-band datapath; only reads snap[], so new-window accumulation never interferes
  always_comb begin
    s        = snap[idx];
    lv_dec   = level[idx] > DEC ? level[idx] - DEC : '0;
    pk_dec   = peak[idx] > DEC ? peak[idx] - DEC : '0;
    lvl_new  = s > lv_dec ? s : lv_dec;
    pk_new   = s >= peak[idx] ? s : hold[idx] != '0 ? peak[idx] : pk_dec > lvl_new ? pk_dec : lvl_new;
    hold_new = s >= peak[idx] ? HW'(HOLD_WINDOWS) : hold[idx] != '0 ? hold[idx] - 1'b1 : hold[idx];
  end
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    go_nxt      = go | (close & (state == ACCUM));
    pending_nxt = pending | (close & (state != ACCUM));
    update      = 1'b0;
    case (state)
      ACCUM: if (go | pending) begin
        state_nxt   = UPDATE;
        idx_nxt     = '0;
        go_nxt      = close;
        pending_nxt = 1'b0;
      end
      UPDATE: begin
        state_nxt = idx == IW'(NUM_BANDS - 1) ? DONE : UPDATE;
        idx_nxt   = idx == IW'(NUM_BANDS - 1) ? idx : idx + 1'b1;
      end
      default: begin
        update      = 1'b1;
        state_nxt   = pending ? UPDATE : ACCUM;
        idx_nxt     = '0;
        pending_nxt = close;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state    <= ACCUM;
      idx      <= '0;
      go       <= 1'b0;
      pending  <= 1'b0;
      win_cnt  <= '0;
      rd_level <= '0;
      rd_peak  <= '0;
      for (int k = 0; k < NUM_BANDS; k++) begin
        win_max[k] <= '0;
        snap[k]    <= '0;
        level[k]   <= '0;
        peak[k]    <= '0;
        hold[k]    <= '0;
      end
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      go      <= go_nxt;
      pending <= pending_nxt;
      if (sample_en) begin
        win_cnt <= win_cnt + 1'b1;
        for (int k = 0; k < NUM_BANDS; k++) begin
          win_max[k] <= close ? '0 : wmx[k];
          if (close) snap[k] <= wmx[k];
        end
      end
      if (state == UPDATE) begin
        level[idx] <= lvl_new;
        peak[idx]  <= pk_new;
        hold[idx]  <= hold_new;
      end
      rd_level <= rd_band < 3'(NUM_BANDS) ? level[rd_band] : '0;
      rd_peak  <= rd_band < 3'(NUM_BANDS) ? peak[rd_band] : '0;
    end
endmodule

// File: tb/tb_band_level_meter.sv
// tb_band_level_meter: random and directed stimulus checked every cycle against a window-level model
module tb_band_level_meter;
  logic clk = 0, reset = 1, sample_en = 0;
  logic [65:0] power_bus = '0;
  logic [2:0] rd_band = '0;
  logic [10:0] rd_level, rd_peak;
  logic update;
  int errors = 0, checks = 0;
  bit run = 0;
  int e = 0, m_close = -1000, m_wcnt = 0;
  int m_wmax[6], m_ol[6], m_nl[6], m_op[6], m_np[6], m_hold[6];
  logic [10:0] exp_lvl = '0, exp_pk = '0;
  logic exp_upd = 0;
  bit pin_on = 0;
  int pin_lvl, pin_pk;
  logic pin_upd;
  string pin_name;
  int ex_l2[5] = '{496, 492, 488, 484, 480};
  int ex_p2[5] = '{500, 500, 500, 500, 496};

  band_level_meter dut (.clk(clk), .reset(reset), .sample_en(sample_en), .power_bus(power_bus),
    .rd_band(rd_band), .rd_level(rd_level), .rd_peak(rd_peak), .update(update));

  always #5 clk = ~clk;

  // Model: band k takes its new value at the edge close+2+k; update is seen right after edge close+7
  always @(posedge clk) begin
    e++;
    if (reset) begin
      for (int k = 0; k < 6; k++) begin
        m_wmax[k] = 0; m_ol[k] = 0; m_nl[k] = 0; m_op[k] = 0; m_np[k] = 0; m_hold[k] = 0;
      end
      m_wcnt = 0; m_close = -1000;
      exp_lvl = '0; exp_pk = '0; exp_upd = 0;
    end else begin
      if (rd_band < 6) begin
        exp_lvl = 11'(m_close + 2 + int'(rd_band) < e ? m_nl[rd_band] : m_ol[rd_band]);
        exp_pk  = 11'(m_close + 2 + int'(rd_band) < e ? m_np[rd_band] : m_op[rd_band]);
      end else begin
        exp_lvl = '0; exp_pk = '0;
      end
      exp_upd = (e - m_close == 7);
      if (sample_en) begin
        for (int k = 0; k < 6; k++) begin
          int p, sv, ld, pd;
          p = int'(power_bus[k*11 +: 11]);
          if (p > m_wmax[k]) m_wmax[k] = p;
          if (m_wcnt == 255) begin
            sv = m_wmax[k];
            m_ol[k] = m_nl[k]; m_op[k] = m_np[k];
            ld = m_ol[k] > 4 ? m_ol[k] - 4 : 0;
            m_nl[k] = sv > ld ? sv : ld;
            if (sv >= m_op[k]) begin m_np[k] = sv; m_hold[k] = 4; end
            else if (m_hold[k] != 0) m_hold[k]--;
            else begin
              pd = m_op[k] > 4 ? m_op[k] - 4 : 0;
              m_np[k] = pd > m_nl[k] ? pd : m_nl[k];
            end
            m_wmax[k] = 0;
          end
        end
        if (m_wcnt == 255) m_close = e;
        m_wcnt = (m_wcnt + 1) % 256;
      end
    end
  end

  always @(negedge clk) if (run) begin
    checks += 3;
    if (rd_level !== exp_lvl) begin errors++; $display("FAIL model rd_level band %0d: got %0d want %0d", rd_band, rd_level, exp_lvl); end
    if (rd_peak !== exp_pk) begin errors++; $display("FAIL model rd_peak band %0d: got %0d want %0d", rd_band, rd_peak, exp_pk); end
    if (update !== exp_upd) begin errors++; $display("FAIL model update: got %b want %b", update, exp_upd); end
    if (pin_on) begin
      checks++;
      if (update !== pin_upd) begin errors++; $display("FAIL %s update: got %b want %b", pin_name, update, pin_upd); end
      if (pin_lvl >= 0) begin
        checks++;
        if (rd_level !== 11'(pin_lvl)) begin errors++; $display("FAIL %s rd_level: got %0d want %0d", pin_name, rd_level, pin_lvl); end
      end
      if (pin_pk >= 0) begin
        checks++;
        if (rd_peak !== 11'(pin_pk)) begin errors++; $display("FAIL %s rd_peak: got %0d want %0d", pin_name, rd_peak, pin_pk); end
      end
    end
  end

  function automatic logic [65:0] pack(input int v0, v1, v2, v3, v4, v5);
    return {11'(v5), 11'(v4), 11'(v3), 11'(v2), 11'(v1), 11'(v0)};
  endfunction

  function automatic logic [65:0] rnd_pb();
    logic [65:0] pb;
    for (int k = 0; k < 6; k++)
      pb[k*11 +: 11] = 11'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 2047));
    return pb;
  endfunction

  task automatic strobe(input logic [65:0] pb);
    sample_en = 1; power_bus = pb;
    @(posedge clk); #1;
    sample_en = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pin(input string name, input int band, input int lvl, input int pk, input logic upd);
    sample_en = 0; rd_band = 3'(band);
    @(posedge clk); #1;
    pin_name = name; pin_lvl = lvl; pin_pk = pk; pin_upd = upd; pin_on = 1;
    @(negedge clk); #1;
    pin_on = 0;
  endtask

  task automatic latency(input string name);
    for (int i = 0; i < 6; i++) pin(name, 0, -1, -1, 0);
    pin(name, 0, -1, -1, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    run = 1;
    idle(2);
    reset = 0;
    for (int k = 0; k < 8; k++) pin("reset_state", k, 0, 0, 0);
    repeat (256) strobe('0);
    latency("zero_latency");
    for (int k = 0; k < 6; k++) pin("zero_levels", k, 0, 0, 0);
    for (int i = 0; i < 256; i++)
      strobe(pack(i == 0 ? 10 : i == 1 ? 700 : i == 2 ? 3 : 0, 0, 500, 123, 2, 0));
    idle(10);
    pin("b0_max", 0, 700, 700, 0);
    pin("b1_zero", 1, 0, 0, 0);
    pin("b2_first", 2, 500, 500, 0);
    pin("b4_first", 4, 2, 2, 0);
    pin("b5_zero", 5, 0, 0, 0);
    pin("rd_band3", 3, 123, 123, 0);
    pin("rd_band7", 7, 0, 0, 0);
    for (int w = 0; w < 5; w++) begin
      repeat (256) strobe('0);
      idle(10);
      pin("b2_decay", 2, ex_l2[w], ex_p2[w], 0);
      if (w == 0) pin("b4_saturate", 4, 0, 2, 0);
    end
    pin("b4_peak_out", 4, 0, 0, 0);
    pin("b0_decay", 0, 680, 696, 0);
    repeat (3000) begin
      sample_en = $urandom_range(0, 3) != 0;
      power_bus = rnd_pb();
      rd_band = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
    end
    sample_en = 0;
    idle(12);
    repeat (256 - m_wcnt) strobe(rnd_pb());
    idle(3);
    reset = 1;
    idle(1);
    reset = 0;
    for (int k = 0; k < 6; k++) pin("reset_mid_update", k, 0, 0, 0);
    repeat (255) strobe(rnd_pb());
    idle(12);
    pin("no_early_update", 0, 0, 0, 0);
    strobe(rnd_pb());
    latency("restart_latency");
    idle(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
